// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline stall/flush request and control bundle
interface pipe_ctrl_if;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;

    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall merge, exception flush sequencing, perf counters and stall watchdog
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
    parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus,
    input  logic          perf_clr_i,
    output logic [31:0]   stall_cycles_o,
    output logic [15:0]   flush_count_o,
    output logic          stall_timeout_o
);
    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_BLANK = 1'b1;
    localparam int         WD_W    = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

    logic [0:0]      state;
    logic [31:0]     stall_cnt;
    logic [15:0]     flush_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;
    logic [5:0]      stall_c;
    logic            flush_c;
    logic [31:0]     new_pc_c;

    // Pipeline registers sample these on the same edge, so they stay purely combinational.
    always_comb begin
        stall_c  = 6'b000000;
        flush_c  = 1'b0;
        new_pc_c = 32'h0;
        if (rst) begin
            if (state == S_RUN && bus.excepttype_i != 32'h0) begin
                flush_c = 1'b1;
                case (bus.excepttype_i)
                    32'h0000_0001: new_pc_c = INT_VECTOR;
                    32'h0000_000e: new_pc_c = bus.cp0_epc_i;
                    default:       new_pc_c = EXC_VECTOR;
                endcase
            end else if (bus.stallreq_from_mem) begin
                stall_c = 6'b011111;
            end else if (bus.stallreq_from_ex) begin
                stall_c = 6'b001111;
            end else if (bus.stallreq_from_id || bus.stallreq_from_if) begin
                stall_c = 6'b000111;
            end
        end
    end

    assign bus.stall       = stall_c;
    assign bus.flush       = flush_c;
    assign bus.new_pc      = new_pc_c;
    assign stall_cycles_o  = stall_cnt;
    assign flush_count_o   = flush_cnt;
    assign stall_timeout_o = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_RUN;
            stall_cnt <= 32'h0;
            flush_cnt <= 16'h0;
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= flush_c ? S_BLANK : S_RUN;
            if (perf_clr_i) begin
                stall_cnt <= 32'h0;
                flush_cnt <= 16'h0;
                wd_cnt    <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (stall_c != 6'b0 && stall_cnt != 32'hFFFF_FFFF)
                    stall_cnt <= stall_cnt + 32'h1;
                if (flush_c && flush_cnt != 16'hFFFF)
                    flush_cnt <= flush_cnt + 16'h1;
                // Counter parks at the limit; the flag follows one edge later and is sticky.
                if (wd_cnt == WD_MAX)
                    timeout_q <= 1'b1;
                if (!stall_c[0] || flush_c)
                    wd_cnt <= '0;
                else if (wd_cnt != WD_MAX)
                    wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed bench with reference model for pipe_ctrl
module tb_pipe_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        perf_clr = 1'b0;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic        stall_timeout;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.STALL_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .perf_clr_i(perf_clr),
        .stall_cycles_o(stall_cycles), .flush_count_o(flush_count),
        .stall_timeout_o(stall_timeout)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: the previous cycle flushed => this cycle ignores exceptions.
    logic        m_blank = 1'b0;
    logic [31:0] m_sc = 32'h0;
    logic [15:0] m_fc = 16'h0;
    int          m_run = 0;
    logic        m_to = 1'b0;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;

    always_comb begin
        e_flush = rst && !m_blank && bus.excepttype_i != 32'h0;
        e_stall = 6'h00;
        if (rst && !e_flush) begin
            if (bus.stallreq_from_mem)                           e_stall = 6'h1f;
            else if (bus.stallreq_from_ex)                       e_stall = 6'h0f;
            else if (bus.stallreq_from_id || bus.stallreq_from_if) e_stall = 6'h07;
        end
        e_pc = 32'h0;
        if (e_flush) begin
            if (bus.excepttype_i == 32'h1)      e_pc = 32'h20;
            else if (bus.excepttype_i == 32'he) e_pc = bus.cp0_epc_i;
            else                                e_pc = 32'h40;
        end
    end

    always @(posedge clk) begin
        logic       f;
        logic [5:0] s;
        f = e_flush;
        s = e_stall;
        if (!rst) begin
            m_blank = 1'b0; m_sc = 0; m_fc = 0; m_run = 0; m_to = 1'b0;
        end else begin
            m_blank = f;
            if (perf_clr) begin
                m_sc = 0; m_fc = 0; m_run = 0; m_to = 1'b0;
            end else begin
                if (s != 0 && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
                if (f && m_fc != 16'hFFFF) m_fc = m_fc + 1;
                if (m_run == TO) m_to = 1'b1;
                if (!s[0] || f) m_run = 0;
                else if (m_run < TO) m_run = m_run + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("stall", {26'h0, bus.stall}, {26'h0, e_stall});
        chk("flush", {31'h0, bus.flush}, {31'h0, e_flush});
        chk("new_pc", bus.new_pc, e_pc);
        chk("stall_cycles", stall_cycles, m_sc);
        chk("flush_count", {16'h0, flush_count}, {16'h0, m_fc});
        chk("stall_timeout", {31'h0, stall_timeout}, {31'h0, m_to});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reqs(logic i_if, logic i_id, logic i_ex, logic i_mem);
        bus.stallreq_from_if  = i_if;
        bus.stallreq_from_id  = i_id;
        bus.stallreq_from_ex  = i_ex;
        bus.stallreq_from_mem = i_mem;
    endtask

    initial begin
        reqs(1, 1, 1, 1);
        bus.excepttype_i = 32'h0;
        bus.cp0_epc_i    = 32'h0;
        @(negedge clk);
        chk("lit_rst_stall", {26'h0, bus.stall}, 32'h0);
        chk("lit_rst_flush", {31'h0, bus.flush}, 32'h0);
        tick(); tick();

        rst = 1'b1;
        reqs(0, 1, 0, 1);
        @(negedge clk);
        chk("lit_mem_id", {26'h0, bus.stall}, 32'h1f);
        tick();
        reqs(0, 1, 0, 0);
        @(negedge clk);
        chk("lit_id", {26'h0, bus.stall}, 32'h07);
        tick();
        reqs(0, 0, 0, 0);
        @(negedge clk);
        chk("lit_sc_2", stall_cycles, 32'd2);
        tick();

        // Exception with a simultaneous ex stall, held into the blank cycle.
        bus.excepttype_i = 32'h8;
        reqs(0, 0, 1, 0);
        @(negedge clk);
        chk("lit_exc_flush", {31'h0, bus.flush}, 32'h1);
        chk("lit_exc_pc", bus.new_pc, 32'h40);
        chk("lit_exc_stall", {26'h0, bus.stall}, 32'h0);
        tick();
        @(negedge clk);
        chk("lit_blank_flush", {31'h0, bus.flush}, 32'h0);
        chk("lit_blank_stall", {26'h0, bus.stall}, 32'h0f);
        tick();
        bus.excepttype_i = 32'h0;
        reqs(0, 0, 0, 0);
        @(negedge clk);
        chk("lit_fc_1", {16'h0, flush_count}, 32'h1);
        tick();

        bus.excepttype_i = 32'he;
        bus.cp0_epc_i    = 32'hBFC0_0100;
        @(negedge clk);
        chk("lit_eret_pc", bus.new_pc, 32'hBFC0_0100);
        tick();
        bus.excepttype_i = 32'h0;
        tick();
        bus.excepttype_i = 32'h1;
        @(negedge clk);
        chk("lit_int_pc", bus.new_pc, 32'h20);
        tick();
        bus.excepttype_i = 32'h0;
        tick();

        // Held exception: flush, blank, flush.
        bus.excepttype_i = 32'hc;
        reqs(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_b2b_flush", {31'h0, bus.flush}, (i == 1) ? 32'h0 : 32'h1);
            tick();
        end
        bus.excepttype_i = 32'h1234;
        tick();
        bus.excepttype_i = 32'h0;
        reqs(0, 0, 0, 0);
        tick();

        // Watchdog: counter reaches TO after 4 stalled edges, flag lands on the 5th.
        reqs(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("lit_wd_flag", {31'h0, stall_timeout}, (i >= 5) ? 32'h1 : 32'h0);
            tick();
        end
        reqs(0, 0, 0, 0);
        @(negedge clk);
        chk("lit_wd_sticky", {31'h0, stall_timeout}, 32'h1);
        tick();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        @(negedge clk);
        chk("lit_wd_clr", {31'h0, stall_timeout}, 32'h0);
        tick();

        // Stall counter saturation via preload.
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        m_sc = 32'hFFFF_FFFD;
        reqs(0, 0, 0, 1);
        repeat (4) tick();
        @(negedge clk);
        chk("lit_sc_sat", stall_cycles, 32'hFFFF_FFFF);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        reqs(0, 0, 0, 0);
        @(negedge clk);
        chk("lit_sc_clr", stall_cycles, 32'h0);
        tick();

        // Reset asserted during BLANK, released with an exception pending.
        bus.excepttype_i = 32'h8;
        tick();
        rst = 1'b0;
        bus.excepttype_i = 32'hc;
        @(negedge clk);
        chk("lit_rst_blank_flush", {31'h0, bus.flush}, 32'h0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("lit_post_rst_flush", {31'h0, bus.flush}, 32'h1);
        chk("lit_post_rst_pc", bus.new_pc, 32'h40);
        tick();
        bus.excepttype_i = 32'h0;
        tick();
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
